spi_tx: RTL and testbench

SPI_TX -- requirements
Module: spi_tx

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_clkgen.sv | 49 ++++
 rtl/spi_tx.sv | 151 +++++++++++++++
 tb/tb_spi_tx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI master definitions: FSM state encoding, SPI mode
// constants as {CKP,CPH} and default frame geometry.
package spi_pkg;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_CLK_DIV = 2;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        TRANSFER = 3'd2,
        HOLD     = 3'd3,
        FINISH   = 3'd4
    } spi_state_t;

    function automatic logic in_frame(input spi_state_t s);
        return (s == SETUP) || (s == TRANSFER) || (s == HOLD);
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCK half-period timer: tick every CLK_DIV cycles while enabled,
// lead/trail strobes and SCK level while toggling is allowed.
module spi_clkgen
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic toggle_en,
    input  logic ckp,
    output logic tick,
    output logic lead,
    output logic trail,
    output logic sck
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          phase_q;

    assign tick  = en && (cnt_q == LAST);
    assign lead  = tick && toggle_en && !phase_q;
    assign trail = tick && toggle_en && phase_q;
    assign sck   = ckp ^ phase_q;

    // Half-period counter and SCK phase; both park at zero when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (!en) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            if (tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (tick && toggle_en) begin
                phase_q <= ~phase_q;
            end
        end
    end

endmodule

// File: rtl/spi_tx.sv
// SPI master, one WIDTH-bit frame per START, all four SPI modes.
// Define SPI_TX_BURST_EN to chain frames without releasing SS.
module spi_tx
    import spi_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CKP,
    input  logic             CPH,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             MISO,
    output logic             SCK,
    output logic             SS,
    output logic             MOSI,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    spi_state_t state_q;
    spi_state_t state_d;

    logic             ckp_q;
    logic             cph_q;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] data_out_q;
    logic [BW-1:0]    bit_q;
    logic             done_q;

    logic tick;
    logic lead;
    logic trail;
    logic sck_gen;
    logic frame_on;
    logic accept;
    logic last_bit;
    logic burst_go;

    assign frame_on = in_frame(state_q);
    assign accept   = START && (state_q == IDLE || state_q == FINISH);
    assign last_bit = (bit_q == LAST_BIT);

`ifdef SPI_TX_BURST_EN
    assign burst_go = (state_q == HOLD) && tick && START;
`else
    assign burst_go = 1'b0;
`endif

    spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk       (CLK),
        .rst_n     (RESET),
        .en        (frame_on),
        .toggle_en (state_q == TRANSFER),
        .ckp       (ckp_q),
        .tick      (tick),
        .lead      (lead),
        .trail     (trail),
        .sck       (sck_gen)
    );

    assign SCK      = (state_q == IDLE) ? CKP : sck_gen;
    assign SS       = ~frame_on;
    assign MOSI     = frame_on & tx_q[WIDTH-1];
    assign BUSY     = frame_on;
    assign DONE     = done_q;
    assign DATA_OUT = data_out_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (START) state_d = SETUP;
            SETUP:    if (tick) state_d = TRANSFER;
            TRANSFER: if (trail && last_bit) state_d = HOLD;
            HOLD: begin
                if (burst_go) begin
                    state_d = TRANSFER;
                end else if (tick) begin
                    state_d = FINISH;
                end
            end
            FINISH:   state_d = START ? SETUP : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Frame latch, shift registers, bit counter and completion strobe.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ckp_q      <= 1'b0;
            cph_q      <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            bit_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                tx_q  <= DATA_IN;
                ckp_q <= CKP;
                cph_q <= CPH;
                bit_q <= '0;
            end else if (burst_go) begin
                tx_q       <= DATA_IN;
                bit_q      <= '0;
                done_q     <= 1'b1;
                data_out_q <= rx_q;
            end else if (state_q == HOLD && tick) begin
                done_q     <= 1'b1;
                data_out_q <= rx_q;
            end else begin
                if (lead) begin
                    if (!cph_q) begin
                        rx_q <= {rx_q[WIDTH-2:0], MISO};
                    end else if (bit_q != '0) begin
                        tx_q <= {tx_q[WIDTH-2:0], 1'b0};
                    end
                end
                if (trail) begin
                    if (cph_q) begin
                        rx_q <= {rx_q[WIDTH-2:0], MISO};
                    end else if (!last_bit) begin
                        tx_q <= {tx_q[WIDTH-2:0], 1'b0};
                    end
                    bit_q <= bit_q + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_tx.sv
// Self-checking bench for spi_tx: mode vectors against a slave model,
// plus hold-START, abort, back-to-back and mid-frame CKP sequences.
module tb_spi_tx;
    import spi_pkg::*;

    localparam int W   = 16;
    localparam int DIV = 2;
    localparam int LAT = DIV * (2 * W + 2);

`ifdef SPI_TX_BURST_EN
    localparam logic BURST = 1'b1;
`else
    localparam logic BURST = 1'b0;
`endif

    typedef struct {
        logic [1:0]   mode;
        logic         loop;
        logic [W-1:0] din;
        logic [W-1:0] pre;
        logic [W-1:0] exp;
    } vec_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         ckp   = 1'b0;
    logic         cph   = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] din   = '0;
    logic         miso;
    logic         sck;
    logic         ss;
    logic         mosi;
    logic [W-1:0] dout;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic         loop  = 1'b0;
    logic         s_ckp = 1'b0;
    logic         s_cph = 1'b0;
    logic [W-1:0] s_pre = '0;

    logic [W-1:0] s_rx     = '0;
    logic         s_miso   = 1'b0;
    logic         s_act    = 1'b0;
    logic         sck_prev = 1'b0;
    int           s_idx    = 0;
    int           rise_cnt = 0;
    int           done_cnt = 0;

    always #5 clk = ~clk;

    spi_tx #(
        .WIDTH   (W),
        .CLK_DIV (DIV)
    ) dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .CKP      (ckp),
        .CPH      (cph),
        .START    (start),
        .DATA_IN  (din),
        .MISO     (miso),
        .SCK      (sck),
        .SS       (ss),
        .MOSI     (mosi),
        .DATA_OUT (dout),
        .BUSY     (busy),
        .DONE     (done)
    );

    assign miso = loop ? mosi : s_miso;

    // Slave model and edge/pulse counters, evaluated mid-cycle.
    always @(negedge clk) begin
        if (sck && !sck_prev) rise_cnt++;
        if (done) done_cnt++;
        if (ss) begin
            s_act = 1'b0;
        end else if (!s_act) begin
            s_act = 1'b1;
            s_idx = s_cph ? W : W - 1;
        end else if (sck !== sck_prev) begin
            if (sck_prev == s_ckp) begin
                if (!s_cph) s_rx = {s_rx[W-2:0], mosi};
                else s_idx--;
            end else begin
                if (s_cph) s_rx = {s_rx[W-2:0], mosi};
                else s_idx--;
            end
        end
        s_miso   = (s_act && s_idx >= 0 && s_idx < W) ? s_pre[s_idx] : 1'b0;
        sck_prev = sck;
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        ckp   = m[1];
        cph   = m[0];
        s_ckp = m[1];
        s_cph = m[0];
        tick_n(2);
    endtask

    task automatic frame(input logic [W-1:0] d, output int lat);
        din   = d;
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 200) begin
            tick_n(1);
            lat++;
        end
    endtask

    vec_t vecs[6];

    initial begin
        int lat;
        int r0;
        int d0;
        int n;
        int edges;
        int bad;
        logic prev;
        logic e;
        logic ckp0;
        logic ss_hi;

        vecs[0] = '{MODE0, 1'b1, 16'hA5C3, 16'h0000, 16'hA5C3};
        vecs[1] = '{MODE1, 1'b0, 16'h1234, 16'h0705, 16'h0705};
        vecs[2] = '{MODE2, 1'b0, 16'hABCD, 16'h0705, 16'h0705};
        vecs[3] = '{MODE3, 1'b0, 16'h5A5A, 16'h0705, 16'h0705};
        vecs[4] = '{MODE0, 1'b0, 16'hFFFF, 16'h8001, 16'h8001};
        vecs[5] = '{MODE3, 1'b0, 16'h0001, 16'hFFFE, 16'hFFFE};

        // Reset state, SCK follows live CKP
        ckp = 1'b1;
        tick_n(3);
        check("rst_ss", ss, 1);
        check("rst_sck", sck, 1);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        rst_n = 1'b1;
        tick_n(2);

        for (int v = 0; v < 6; v++) begin
            set_mode(vecs[v].mode);
            loop  = vecs[v].loop;
            s_pre = vecs[v].pre;
            check("idle_sck", sck, vecs[v].mode[1]);
            r0 = rise_cnt;
            d0 = done_cnt;
            frame(vecs[v].din, lat);
            check("latency", lat, LAT);
            check("dout", dout, vecs[v].exp);
            check("fin_sck", sck, vecs[v].mode[1]);
            check("fin_ss", ss, 1);
            check("fin_busy", busy, 0);
            tick_n(4);
            check("rises", rise_cnt - r0, W);
            check("dones", done_cnt - d0, 1);
            check("after_sck", sck, vecs[v].mode[1]);
            check("after_mosi", mosi, 0);
            if (!vecs[v].loop) check("slave_rx", s_rx, vecs[v].din);
        end

        // START held for several cycles: one frame only
        set_mode(MODE0);
        loop  = 1'b1;
        d0    = done_cnt;
        din   = 16'h3C96;
        start = 1'b1;
        tick_n(4);
        start = 1'b0;
        lat   = 3;
        while (!done && lat < 200) begin
            tick_n(1);
            lat++;
        end
        check("hold_start_lat", lat, LAT);
        tick_n(80);
        check("hold_start_dones", done_cnt - d0, 1);
        check("hold_start_dout", dout, 16'h3C96);
        check("hold_start_busy", busy, 0);

        // CKP flipped mid-frame leaves SCK waveform intact
        set_mode(MODE2);
        ckp0  = ckp;
        bad   = 0;
        din   = 16'h6B1E;
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            tick_n(1);
            if (i == 20) ckp = ~ckp;
            e = ckp0;
            if (i >= DIV && i < DIV + 2 * W * DIV)
                e = ckp0 ^ logic'(((i - DIV) / DIV) % 2);
            if (sck !== e) bad++;
        end
        check("ckp_flip_wave", bad, 0);
        check("ckp_flip_done", done, 1);
        check("ckp_flip_dout", dout, 16'h6B1E);
        ckp = ckp0;
        tick_n(2);

        // Abort at the 10th SCK edge
        set_mode(MODE0);
        edges = 0;
        n     = 0;
        prev  = sck;
        din   = 16'hC0DE;
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        while (edges < 10 && n < 200) begin
            tick_n(1);
            n++;
            if (sck !== prev) edges++;
            prev = sck;
        end
        check("abort_edges", edges, 10);
        rst_n = 1'b0;
        tick_n(1);
        check("abort_ss", ss, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dout", dout, 0);
        check("abort_mosi", mosi, 0);
        check("abort_sck", sck, ckp);
        rst_n = 1'b1;
        d0    = done_cnt;
        tick_n(80);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_dout_kept", dout, 0);

        // Back-to-back frames with START held across the frame boundary
        set_mode(MODE0);
        d0    = done_cnt;
        din   = 16'h1234;
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        for (int i = 1; i <= LAT - 2; i++) tick_n(1);
        start = 1'b1;
        din   = 16'hABCD;
        n     = 0;
        while (!done && n < 20) begin
            tick_n(1);
            n++;
        end
        check("b2b_done1", done, 1);
        check("b2b_dout1", dout, 16'h1234);
        ss_hi = ss;
        tick_n(1);
        start = 1'b0;
        n     = 0;
        while (!done && n < 200) begin
            ss_hi = ss_hi | ss;
            tick_n(1);
            n++;
        end
        check("b2b_done2", done, 1);
        check("b2b_dout2", dout, 16'hABCD);
        check("b2b_ss_between", ss_hi, !BURST);
        tick_n(4);
        check("b2b_dones", done_cnt - d0, 2);
        check("b2b_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
